// File: rtl/cam_gray_capture.sv
// cam_gray_capture
//   Front end of the stereo pipeline. Samples an RGB565 camera byte stream
//   (vsync/href/din), pairs bytes into 16-bit pixels, converts each pixel to
//   8-bit luma and emits it with its row/column coordinates.
//
// Optional build macro: TEST_PATTERN_EN
//   When defined and test_mode=1, pix carries col[7:0]^row[7:0] of the pixel
//   slot instead of the camera luma. When undefined, test_mode is ignored.
//
// Parameters
//   H_ACTIVE  active pixels per line (extra pixels are dropped)
//   V_ACTIVE  active lines per frame (extra lines are dropped)
//   HI_FIRST  1: first byte of a pair is RGB565[15:8]; 0: first byte is [7:0]
//
// Ports
//   clk          pixel/byte clock, rising edge
//   rst_n        asynchronous active-low reset
//   vsync        frame sync, high between frames
//   href         line valid
//   din[7:0]     camera byte
//   test_mode    test pattern select (TEST_PATTERN_EN builds only)
//   pix[7:0]     luma pixel
//   row[12:0]    row of pix
//   col[12:0]    column of pix
//   pix_valid    pix/row/col valid this cycle
//   frame_start  one-cycle pulse on vsync falling edge
//   sync_err     sticky partial-pixel flag, cleared by frame_start
module cam_gray_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    input  logic        test_mode,
    output logic [7:0]  pix,
    output logic [12:0] row,
    output logic [12:0] col,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        sync_err
);

    localparam logic [12:0] H_MAX = 13'(H_ACTIVE);
    localparam logic [12:0] V_MAX = 13'(V_ACTIVE);

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, HI, LO} state_t;

    state_t      state_reg, state_next;
    logic        vsync_q, vsync_prev, href_q;
    logic [7:0]  din_q;
    logic [7:0]  first_byte;
    logic [12:0] col_cnt, row_cnt;

    logic vsync_rise, vsync_fall;
    logic start_frame, latch_first, take_word, end_line, set_err;

    // Input registers; edges are taken against the previous registered sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            vsync_prev <= 1'b0;
            href_q     <= 1'b0;
            din_q      <= 8'd0;
        end else begin
            vsync_q    <= vsync;
            vsync_prev <= vsync_q;
            href_q     <= href;
            din_q      <= din;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_prev;
    assign vsync_fall = ~vsync_q & vsync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= WAIT_FRAME;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        latch_first = 1'b0;
        take_word   = 1'b0;
        end_line    = 1'b0;
        set_err     = 1'b0;
        if (vsync_rise) begin
            // Frame abort wins over everything, including a half-built pixel
            state_next = WAIT_FRAME;
        end else begin
            case (state_reg)
                WAIT_FRAME: if (vsync_fall) begin
                    start_frame = 1'b1;
                    state_next  = WAIT_LINE;
                end
                WAIT_LINE: if (href_q) begin
                    latch_first = 1'b1;
                    state_next  = LO;
                end
                HI: begin
                    if (href_q) begin
                        latch_first = 1'b1;
                        state_next  = LO;
                    end else begin
                        end_line   = 1'b1;
                        state_next = WAIT_LINE;
                    end
                end
                LO: begin
                    if (href_q) begin
                        take_word  = 1'b1;
                        state_next = HI;
                    end else begin
                        set_err    = 1'b1;
                        end_line   = 1'b1;
                        state_next = WAIT_LINE;
                    end
                end
                default: state_next = WAIT_FRAME;
            endcase
        end
    end

    // Position counters, byte latch and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_byte  <= 8'd0;
            col_cnt     <= 13'd0;
            row_cnt     <= 13'd0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_start <= start_frame;
            if (start_frame) begin
                col_cnt  <= 13'd0;
                row_cnt  <= 13'd0;
                sync_err <= 1'b0;
            end else begin
                if (set_err)     sync_err   <= 1'b1;
                if (latch_first) first_byte <= din_q;
                if (take_word && col_cnt < H_MAX) col_cnt <= col_cnt + 13'd1;
                // A line with no complete pixel does not consume a row
                if (end_line && col_cnt != 13'd0) begin
                    col_cnt <= 13'd0;
                    if (row_cnt < V_MAX) row_cnt <= row_cnt + 13'd1;
                end
            end
        end
    end

    // RGB565 -> RGB888 by replicating the channel MSBs into the low bits
    logic [15:0] word;
    logic [7:0]  r8, g8, b8;
    assign word = HI_FIRST ? {first_byte, din_q} : {din_q, first_byte};
    assign r8   = {word[15:11], word[15:13]};
    assign g8   = {word[10:5],  word[10:9]};
    assign b8   = {word[4:0],   word[4:2]};

    // Stage 1: weighted products and the slot coordinates
    logic        s1_valid;
    logic [12:0] s1_row, s1_col;
    logic [15:0] s1_pr, s1_pg, s1_pb;
`ifdef TEST_PATTERN_EN
    logic        s1_tp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_row   <= 13'd0;
            s1_col   <= 13'd0;
            s1_pr    <= 16'd0;
            s1_pg    <= 16'd0;
            s1_pb    <= 16'd0;
`ifdef TEST_PATTERN_EN
            s1_tp    <= 1'b0;
`endif
        end else begin
            // Out-of-window slots still advance timing but never reach the output
            s1_valid <= take_word && (col_cnt < H_MAX) && (row_cnt < V_MAX);
            s1_row   <= row_cnt;
            s1_col   <= col_cnt;
            s1_pr    <= 16'(r8) * 16'd77;
            s1_pg    <= 16'(g8) * 16'd150;
            s1_pb    <= 16'(b8) * 16'd29;
`ifdef TEST_PATTERN_EN
            s1_tp    <= test_mode;
`endif
        end
    end

    // Stage 2: sum (peaks at 65280, fits 16 bits) and divide by 256
    logic [7:0] pix_next;
    always_comb begin
        pix_next = 8'((s1_pr + s1_pg + s1_pb) >> 8);
`ifdef TEST_PATTERN_EN
        if (s1_tp) pix_next = s1_col[7:0] ^ s1_row[7:0];
`endif
    end

`ifndef TEST_PATTERN_EN
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix       <= 8'd0;
            row       <= 13'd0;
            col       <= 13'd0;
        end else begin
            pix_valid <= s1_valid;
            if (s1_valid) begin
                pix <= pix_next;
                row <= s1_row;
                col <= s1_col;
            end
        end
    end

endmodule

// File: doc/cam_gray_capture.md
Name: cam_gray_capture

Overview:
- Front-end stage of the stereo pipeline; feeds the 3x3 hybrid median blur stage.
- Samples the camera's RGB565 byte stream (VSYNC/HREF/8-bit data), pairs bytes into pixels and converts them to 8-bit luma.
- Emits each luma pixel with its row/col coordinates in the format the blur stage consumes.

Parameters:
- H_ACTIVE, 640, active pixels per line; pixels beyond this are dropped.
- V_ACTIVE, 480, active lines per frame; lines beyond this are dropped.
- HI_FIRST, 1, 1: first byte of a pair is RGB565[15:8]; 0: first byte is [7:0].

Ports:
- clk  in  1  pixel/byte clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vsync  in  1  frame sync, high between frames.
- href  in  1  line valid, high while bytes of the active line arrive.
- din  in  8  camera byte.
- test_mode  in  1  selects internal test pattern (only honoured with TEST_PATTERN_EN).
- pix  out  8  luma pixel.
- row  out  13  row of pix, 0..V_ACTIVE-1.
- col  out  13  column of pix, 0..H_ACTIVE-1.
- pix_valid  out  1  pix/row/col valid this cycle.
- frame_start  out  1  one-cycle pulse on the vsync falling edge.
- sync_err  out  1  sticky error flag; cleared by frame_start.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=WAIT_FRAME, counters 0, byte latch 0.
- Inputs are registered once (vsync_q, href_q, din_q). Edges are detected against the previous registered value.
- FSM states:
  - WAIT_FRAME: idle until vsync falls; then frame_start=1 for 1 cycle, row=0, go to WAIT_LINE.
  - WAIT_LINE: on href_q=1, latch byte 0 and go to LO.
  - HI: href_q=1: latch the first byte, go to LO; href_q=0: end of line.
  - LO: href_q=1: form the 16-bit word, start conversion, go to HI; href_q=0: partial pixel, discard, set sync_err, end of line.
- End of line (href falling): if ≥1 pixel was accepted, row+1 and col counter reset to 0; go to WAIT_LINE.
- vsync rising in any state aborts: go to WAIT_FRAME, no output for a partial pixel. Counters are held until the next frame_start.
- Conversion:
  - Expand channels to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y=(77*R8+150*G8+29*B8)>>8, using a 16-bit unsigned sum with no overflow; max 65280 gives 255.
  - Pipeline: products registered in stage 1, sum and shift in stage 2.
- Latency: pix_valid asserts exactly 2 clk after the cycle the second byte is sampled (in din_q). row/col are delayed alongside pix.
- Drop rules, no sync_err: col ≥ H_ACTIVE or row ≥ V_ACTIVE gives no pix_valid. Counters saturate at H_ACTIVE/V_ACTIVE (no wrap).
- Short line (< H_ACTIVE pixels): no error, next line starts at col 0.
- href high while vsync high: ignored, no pixels.
- pix_valid is never asserted in consecutive cycles; pixels arrive at most every 2 clk.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: when test_mode=1, pix = col[7:0] ^ row[7:0] of the pixel slot. Timing, sync handling and counters are unchanged and camera data is ignored.
- Undefined: test_mode is ignored and pix always comes from the camera conversion.

Test Plan:
- Reset mid-line (rst_n low 3 cycles during a pixel pair) -> all outputs 0 at once; no pix_valid until a new vsync fall plus href.
- One frame, 4 lines x 640 pixels, every word 0xFFFF -> 2560 pix_valid pulses, pix=255, col 0..639, row 0..3, frame_start once.
- Words 0xF800, 0x07E0, 0x001F (HI_FIRST=1) -> pix=76, 149, 28, each 2 clk after its second byte.
- Line of 641 pixels, then a line of 3 bytes -> 640 outputs on the first line; second line gives 1 pixel, sync_err=1, cleared at the next frame_start.
- vsync rises mid-line after 100 pixels -> output stops, FSM returns to WAIT_FRAME; the next frame begins at row 0, col 0.
- TEST_PATTERN_EN defined, test_mode=1, row 5, col 3 -> pix=0x06; with macro undefined the same stimulus gives camera luma.
